param_multi_bank_memory: RTL and testbench

//  Parametrised banked RAM: NUM_BANKS single-port banks, one read and one write port at top level.

---
 rtl/param_multi_bank_memory_pkg.sv | 19 +
 rtl/param_multi_bank_memory_bank_sram.sv | 28 ++
 rtl/param_multi_bank_memory.sv | 159 +++++++++++++++
 tb/tb_param_multi_bank_memory.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/param_multi_bank_memory_pkg.sv
// Shared constants and address-split helpers for the banked memory.
// The upper address bits select the bank; the remaining low bits select the row inside that bank.
package pmbm_pkg;

    localparam int DEF_ADDR_W    = 11;
    localparam int DEF_NUM_BANKS = 4;
    localparam int BANK_W        = $clog2(DEF_NUM_BANKS);
    localparam int ROW_W         = DEF_ADDR_W - BANK_W;

    function automatic logic [31:0] bank_of(input logic [31:0] addr, input int addr_w,
                                            input int bank_w);
        return (addr >> (addr_w - bank_w)) & ((32'd1 << bank_w) - 32'd1);
    endfunction

    function automatic logic [31:0] row_of(input logic [31:0] addr, input int row_w);
        return addr & ((32'd1 << row_w) - 32'd1);
    endfunction

endpackage

// File: rtl/param_multi_bank_memory_bank_sram.sv
// Single-port bank: one access per cycle.
// The registered read port returns 0 in any cycle that is not a read.
module bank_sram #(
    parameter int ROW_W  = 9,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ROW_W-1:0]  addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [0:(1<<ROW_W)-1];

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= din;
        end
        if (en && !we) begin
            dout <= mem[addr];
        end else begin
            dout <= '0;
        end
    end

endmodule

// File: rtl/param_multi_bank_memory.sv
// Banked RAM with one read and one write port. A same-bank write collision is parked in a
// 1-entry write buffer, which forwards to reads and is force-drained after MAX_DEFER blocked cycles.
module param_multi_bank_memory
    import pmbm_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int NUM_BANKS = DEF_NUM_BANKS,
    parameter int MAX_DEFER = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ren,
    input  logic [ADDR_W-1:0] raddr,
    output logic              rready,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] din,
    output logic              wready,
    output logic              conflict
);

    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int ROW_BITS  = ADDR_W - BANK_BITS;
    localparam int CNT_W     = $clog2(MAX_DEFER + 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_W'(MAX_DEFER)) ? v : v + 1'b1;
    endfunction

    logic                 wb_valid;
    logic [ADDR_W-1:0]    wb_addr;
    logic [DATA_W-1:0]    wb_data;
    logic [CNT_W-1:0]     defer_cnt;

    logic [BANK_BITS-1:0] rd_bank, wr_bank, wb_bank;
    logic [ROW_BITS-1:0]  rd_row, wr_row, wb_row;

    logic forced, rd_acc, wb_hit, rd_owns, wb_drain, wr_acc, wr_park, wr_commit;

    logic [NUM_BANKS-1:0] bk_en, bk_we, rd_sel;
    logic [ROW_BITS-1:0]  bk_addr [NUM_BANKS];
    logic [DATA_W-1:0]    bk_din  [NUM_BANKS];
    logic [DATA_W-1:0]    bk_dout [NUM_BANKS];

    logic                 vld_p1, fwd_hit_p1, conflict_p1;
    logic [DATA_W-1:0]    fwd_data_p1, rd_mux;
    logic [NUM_BANKS-1:0] rd_sel_p1;

    always_comb begin
        rd_bank = BANK_BITS'(bank_of(32'(raddr), ADDR_W, BANK_BITS));
        wr_bank = BANK_BITS'(bank_of(32'(waddr), ADDR_W, BANK_BITS));
        wb_bank = BANK_BITS'(bank_of(32'(wb_addr), ADDR_W, BANK_BITS));
        rd_row  = ROW_BITS'(row_of(32'(raddr), ROW_BITS));
        wr_row  = ROW_BITS'(row_of(32'(waddr), ROW_BITS));
        wb_row  = ROW_BITS'(row_of(32'(wb_addr), ROW_BITS));
    end

    // A forced drain only ever blocks reads to the buffered bank, so the drain itself
    // reduces to "buffer valid and its bank not claimed by an accepted read".
    assign forced    = wb_valid && (defer_cnt == CNT_W'(MAX_DEFER));
    assign rready    = !(forced && (rd_bank == wb_bank));
    assign wready    = !wb_valid;
    assign rd_acc    = ren && rready;
    assign wb_hit    = rd_acc && wb_valid && (raddr == wb_addr);
    assign rd_owns   = rd_acc && !wb_hit;
    assign wb_drain  = wb_valid && !(rd_owns && (rd_bank == wb_bank));
    assign wr_acc    = wen && wready;
    assign wr_park   = wr_acc && rd_owns && (wr_bank == rd_bank);
    assign wr_commit = wr_acc && !wr_park;

    always_comb begin
        rd_sel = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bk_en[b]   = 1'b0;
            bk_we[b]   = 1'b0;
            bk_addr[b] = '0;
            bk_din[b]  = '0;
            if (rd_owns && (rd_bank == BANK_BITS'(b))) begin
                bk_en[b]   = 1'b1;
                bk_addr[b] = rd_row;
                rd_sel[b]  = 1'b1;
            end else if (wb_drain && (wb_bank == BANK_BITS'(b))) begin
                bk_en[b]   = 1'b1;
                bk_we[b]   = 1'b1;
                bk_addr[b] = wb_row;
                bk_din[b]  = wb_data;
            end else if (wr_commit && (wr_bank == BANK_BITS'(b))) begin
                bk_en[b]   = 1'b1;
                bk_we[b]   = 1'b1;
                bk_addr[b] = wr_row;
                bk_din[b]  = din;
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        bank_sram #(
            .ROW_W (ROW_BITS),
            .DATA_W(DATA_W)
        ) u_bank (
            .clk (clk),
            .en  (bk_en[b]),
            .we  (bk_we[b]),
            .addr(bk_addr[b]),
            .din (bk_din[b]),
            .dout(bk_dout[b])
        );
    end

    // p0 -> p1: control state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid    <= 1'b0;
            defer_cnt   <= '0;
            vld_p1      <= 1'b0;
            fwd_hit_p1  <= 1'b0;
            conflict_p1 <= 1'b0;
        end else begin
            vld_p1      <= rd_acc;
            fwd_hit_p1  <= wb_hit;
            conflict_p1 <= wr_park;
            if (wr_park) begin
                wb_valid <= 1'b1;
            end else if (wb_drain) begin
                wb_valid <= 1'b0;
            end
            if (wb_drain || !wb_valid) begin
                defer_cnt <= '0;
            end else begin
                defer_cnt <= sat_inc(defer_cnt);
            end
        end
    end

    // p0 -> p1: data path
    always_ff @(posedge clk) begin
        if (wr_park) begin
            wb_addr <= waddr;
            wb_data <= din;
        end
        fwd_data_p1 <= wb_data;
        rd_sel_p1   <= rd_sel;
    end

    always_comb begin
        rd_mux = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            rd_mux = rd_mux | (bk_dout[b] & {DATA_W{rd_sel_p1[b]}});
        end
    end

    assign rvalid   = vld_p1;
    assign rdata    = vld_p1 ? (fwd_hit_p1 ? fwd_data_p1 : rd_mux) : '0;
    assign conflict = conflict_p1;

endmodule

// File: tb/tb_param_multi_bank_memory.sv
// Directed bench for the banked memory: a reference memory feeds a queue of expected read data
// that is popped when the read result is due one cycle after acceptance.
module tb_param_multi_bank_memory;

    logic        clk = 1'b0;
    logic        rst;
    logic        ren, wen;
    logic [10:0] raddr, waddr;
    logic [7:0]  din;
    logic        rready, rvalid, wready, conflict;
    logic [7:0]  rdata;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q [$];
    logic [7:0] ref_mem [logic [10:0]];

    param_multi_bank_memory #(
        .DATA_W   (8),
        .ADDR_W   (11),
        .NUM_BANKS(4),
        .MAX_DEFER(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ren     (ren),
        .raddr   (raddr),
        .rready  (rready),
        .rvalid  (rvalid),
        .rdata   (rdata),
        .wen     (wen),
        .waddr   (waddr),
        .din     (din),
        .wready  (wready),
        .conflict(conflict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic [10:0] ra,
                        input logic w, input logic [10:0] wa, input logic [7:0] d,
                        input logic exp_rr, input logic exp_wr, input logic exp_conf);
        logic [7:0] ed;
        ren = r; raddr = ra; wen = w; waddr = wa; din = d;
        @(negedge clk);
        chk({tag, ".rready"}, 32'(rready), 32'(exp_rr));
        chk({tag, ".wready"}, 32'(wready), 32'(exp_wr));
        if (r && exp_rr) exp_q.push_back(ref_mem.exists(ra) ? ref_mem[ra] : 8'h00);
        if (w && exp_wr) ref_mem[wa] = d;
        @(posedge clk);
        #1;
        chk({tag, ".conflict"}, 32'(conflict), 32'(exp_conf));
        if (exp_q.size() > 0) begin
            ed = exp_q.pop_front();
            chk({tag, ".rvalid"}, 32'(rvalid), 32'd1);
            chk({tag, ".rdata"}, 32'(rdata), 32'(ed));
        end else begin
            chk({tag, ".rvalid"}, 32'(rvalid), 32'd0);
            chk({tag, ".rdata"}, 32'(rdata), 32'd0);
        end
        ren = 1'b0; wen = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ren = 1'b0; wen = 1'b0; raddr = '0; waddr = '0; din = '0;
        #3;
        chk("reset.rvalid", 32'(rvalid), 32'd0);
        chk("reset.rdata", 32'(rdata), 32'd0);
        chk("reset.conflict", 32'(conflict), 32'd0);
        chk("reset.wready", 32'(wready), 32'd1);
        chk("reset.rready", 32'(rready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // basic write then read
        step("t2.wr",   0, 11'h000, 1, 11'h0A5, 8'h3C, 1, 1, 0);
        step("t2.rd",   1, 11'h0A5, 0, 11'h000, 8'h00, 1, 1, 0);
        // read bank0 while writing bank1
        step("t3.par",  1, 11'h0A5, 1, 11'h2FF, 8'h11, 1, 1, 0);
        step("t3.rd",   1, 11'h2FF, 0, 11'h000, 8'h00, 1, 1, 0);
        // preloads
        step("pre.010", 0, 11'h000, 1, 11'h010, 8'h55, 1, 1, 0);
        step("pre.020", 0, 11'h000, 1, 11'h020, 8'hA1, 1, 1, 0);
        step("pre.030", 0, 11'h000, 1, 11'h030, 8'hB2, 1, 1, 0);
        step("pre.4a0", 0, 11'h000, 1, 11'h4A0, 8'hC3, 1, 1, 0);
        step("pre.chk", 1, 11'h010, 0, 11'h000, 8'h00, 1, 1, 0);
        // same-bank collision, idle drain, read back
        step("t4.park", 1, 11'h020, 1, 11'h010, 8'h77, 1, 1, 1);
        step("t4.idle", 0, 11'h000, 0, 11'h000, 8'h00, 1, 0, 0);
        step("t4.rd",   1, 11'h010, 0, 11'h000, 8'h00, 1, 1, 0);
        // same address same cycle returns old data, then forwarded from the buffer
        step("t5.park", 1, 11'h010, 1, 11'h010, 8'h88, 1, 1, 1);
        step("t5.fwd",  1, 11'h010, 0, 11'h000, 8'h00, 1, 0, 0);
        step("t5.free", 0, 11'h000, 0, 11'h000, 8'h00, 1, 1, 0);
        step("t5.rd",   1, 11'h010, 0, 11'h000, 8'h00, 1, 1, 0);
        // starvation: four blocked cycles, then forced drain stalls the same-bank read
        step("t6.park", 1, 11'h020, 1, 11'h010, 8'h5A, 1, 1, 1);
        for (int i = 0; i < 4; i++) begin
            step("t6.blk", 1, 11'h030, 0, 11'h000, 8'h00, 1, 0, 0);
        end
        step("t6.force", 1, 11'h030, 0, 11'h000, 8'h00, 0, 0, 0);
        step("t6.after", 1, 11'h030, 0, 11'h000, 8'h00, 1, 1, 0);
        step("t6.rd",    1, 11'h010, 0, 11'h000, 8'h00, 1, 1, 0);
        // forced drain cycle with a read to another bank
        step("t6b.park", 1, 11'h020, 1, 11'h010, 8'h6B, 1, 1, 1);
        for (int i = 0; i < 4; i++) begin
            step("t6b.blk", 1, 11'h030, 0, 11'h000, 8'h00, 1, 0, 0);
        end
        step("t6b.bank2", 1, 11'h4A0, 0, 11'h000, 8'h00, 1, 0, 0);
        step("t6b.free",  0, 11'h000, 0, 11'h000, 8'h00, 1, 1, 0);
        step("t6b.rd",    1, 11'h010, 0, 11'h000, 8'h00, 1, 1, 0);
        // asynchronous reset with a parked write and a read in flight
        step("t1.park", 1, 11'h020, 1, 11'h040, 8'h99, 1, 1, 1);
        ref_mem.delete(11'h040);
        #1;
        rst = 1'b1;
        #1;
        chk("t1.rvalid", 32'(rvalid), 32'd0);
        chk("t1.rdata", 32'(rdata), 32'd0);
        chk("t1.conflict", 32'(conflict), 32'd0);
        chk("t1.wready", 32'(wready), 32'd1);
        chk("t1.rready", 32'(rready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("t1.post_rvalid", 32'(rvalid), 32'd0);
        chk("t1.post_wready", 32'(wready), 32'd1);
        step("t1.rd", 1, 11'h0A5, 0, 11'h000, 8'h00, 1, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
